// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the fetch-side PC sequencer.
package pc_sequencer_pkg;

  localparam int PB = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } pc_seq_state_t;

  // Sequential PC advance; wraps modulo 2^PB with no carry out.
  function automatic logic [PB-1:0] pc_advance(input logic [PB-1:0] pc,
                                               input logic [PB-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Architectural PC register with load enable and asynchronous active-low reset.
module pc_sequencer_pc_reg
  import pc_sequencer_pkg::*;
#(
  parameter logic [PB-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PB-1:0] d,
  output logic [PB-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, issues imem requests, applies redirects
// (squashing the wrong-path fetch) and drains into a terminal halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PB-1:0] RESET_PC = '0,
  parameter logic [PB-1:0] PC_STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [PB-1:0] target_i,
  input  logic          halt_i,
  input  logic          imem_ready_i,
  output logic          imem_req_o,
  output logic [PB-1:0] pc_o,
  output logic          ir_valid_o,
  output logic          flush_o,
  output logic          halted_o
);

  pc_seq_state_t state_reg, state_next;
  logic          out_reg, out_next;
  logic          pend_reg, pend_next;
  logic [PB-1:0] pend_tgt_reg, pend_tgt_next;
  logic          ir_valid_reg, ir_valid_next;
  logic          flush_reg, flush_next;
  logic          halted_reg, halted_next;
  logic          pc_load;
  logic [PB-1:0] pc_d;
  logic          active;
  logic          accept;

  pc_sequencer_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_d),
    .q   (pc_o)
  );

  // A raised request is held through stalls until the memory takes it.
  assign active     = (state_reg == RUN) || (state_reg == DRAIN);
  assign imem_req_o = active && (!stall_i || out_reg);
  assign accept     = imem_req_o && imem_ready_i;

  always_comb begin
    state_next    = state_reg;
    out_next      = 1'b0;
    pend_next     = pend_reg;
    pend_tgt_next = pend_tgt_reg;
    ir_valid_next = 1'b0;
    flush_next    = 1'b0;
    pc_load       = 1'b0;
    pc_d          = pc_o;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN, DRAIN: begin
        if (accept) begin
          pc_load   = 1'b1;
          pend_next = 1'b0;
          if (pend_reg) begin
            pc_d = pend_tgt_reg;
          end else if (redirect_i) begin
            pc_d = target_i;
          end else begin
            pc_d = pc_advance(pc_o, PC_STEP);
          end
          ir_valid_next = !pend_reg && !redirect_i;
          flush_next    = pend_reg || redirect_i;
        end else if (imem_req_o) begin
          // Request waits on memory; a redirect now is remembered and
          // applied when this (wrong-path) fetch finally completes.
          out_next = 1'b1;
          if (redirect_i) begin
            pend_next     = 1'b1;
            pend_tgt_next = target_i;
          end
        end else if (redirect_i) begin
          pc_load    = 1'b1;
          pc_d       = target_i;
          flush_next = 1'b1;
        end

        if (state_reg == RUN && halt_i) begin
          state_next = (imem_req_o && !imem_ready_i) ? DRAIN : HALT;
        end else if (state_reg == DRAIN && accept) begin
          state_next = HALT;
        end
      end
      default: begin
        pend_next = 1'b0;
      end
    endcase

    halted_next = (state_next == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= BOOT;
      out_reg      <= 1'b0;
      pend_reg     <= 1'b0;
      pend_tgt_reg <= '0;
      ir_valid_reg <= 1'b0;
      flush_reg    <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      out_reg      <= out_next;
      pend_reg     <= pend_next;
      pend_tgt_reg <= pend_tgt_next;
      ir_valid_reg <= ir_valid_next;
      flush_reg    <= flush_next;
      halted_reg   <= halted_next;
    end
  end

  assign ir_valid_o = ir_valid_reg;
  assign flush_o    = flush_reg;
  assign halted_o   = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written reset/wrap sequences.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  typedef struct packed {
    logic          stall;
    logic          redirect;
    logic [PB-1:0] target;
    logic          halt;
    logic          ready;
    logic          e_req;
    logic [PB-1:0] e_pc;
    logic          e_irv;
    logic          e_flush;
    logic          e_halted;
  } vec_t;

  localparam int NV = 28;

  logic          clk;
  logic          rst;
  logic          stall_i;
  logic          redirect_i;
  logic [PB-1:0] target_i;
  logic          halt_i;
  logic          imem_ready_i;
  logic          imem_req_o;
  logic [PB-1:0] pc_o;
  logic          ir_valid_o;
  logic          flush_o;
  logic          halted_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  pc_sequencer #(
    .RESET_PC(16'h0000),
    .PC_STEP (16'h0001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .halt_i      (halt_i),
    .imem_ready_i(imem_ready_i),
    .imem_req_o  (imem_req_o),
    .pc_o        (pc_o),
    .ir_valid_o  (ir_valid_o),
    .flush_o     (flush_o),
    .halted_o    (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic rd, input logic [PB-1:0] tg,
                              input logic hl, input logic rdy, input logic req,
                              input logic [PB-1:0] pc, input logic irv, input logic fl,
                              input logic hd);
    vec_t v;
    v.stall = st; v.redirect = rd; v.target = tg; v.halt = hl; v.ready = rdy;
    v.e_req = req; v.e_pc = pc; v.e_irv = irv; v.e_flush = fl; v.e_halted = hd;
    return v;
  endfunction

  task automatic drive(input logic st, input logic rd, input logic [PB-1:0] tg,
                       input logic hl, input logic rdy);
    stall_i = st; redirect_i = rd; target_i = tg; halt_i = hl; imem_ready_i = rdy;
  endtask

  task automatic chk(input string name, input logic req, input logic [PB-1:0] pc,
                     input logic irv, input logic fl, input logic hd);
    checks += 5;
    if (imem_req_o !== req) begin
      errors++;
      $display("FAIL %s req: got %b want %b", name, imem_req_o, req);
    end
    if (pc_o !== pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", name, pc_o, pc);
    end
    if (ir_valid_o !== irv) begin
      errors++;
      $display("FAIL %s ir_valid: got %b want %b", name, ir_valid_o, irv);
    end
    if (flush_o !== fl) begin
      errors++;
      $display("FAIL %s flush: got %b want %b", name, flush_o, fl);
    end
    if (halted_o !== hd) begin
      errors++;
      $display("FAIL %s halted: got %b want %b", name, halted_o, hd);
    end
    $display("%0t %s req=%b pc=%h irv=%b flush=%b halted=%b",
             $time, name, imem_req_o, pc_o, ir_valid_o, flush_o, halted_o);
  endtask

  initial begin
    //               st rd target   hl rdy  req pc       irv fl hd
    vecs[0]  = mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0, 0); // BOOT
    vecs[1]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0000, 0, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0001, 1, 0, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0002, 1, 0, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0003, 1, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0004, 1, 0, 0);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 1,  0, 16'h0005, 1, 0, 0); // stall x3 at 5
    vecs[7]  = mk(1, 0, 16'h0000, 0, 1,  0, 16'h0005, 0, 0, 0);
    vecs[8]  = mk(1, 0, 16'h0000, 0, 1,  0, 16'h0005, 0, 0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0005, 0, 0, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0006, 1, 0, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0,  1, 16'h0007, 1, 0, 0); // wait at 7
    vecs[12] = mk(0, 1, 16'h0040, 0, 0,  1, 16'h0007, 0, 0, 0);
    vecs[13] = mk(1, 0, 16'h0000, 0, 0,  1, 16'h0007, 0, 0, 0);
    vecs[14] = mk(0, 0, 16'h0000, 0, 0,  1, 16'h0007, 0, 0, 0);
    vecs[15] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0007, 0, 0, 0); // squashing accept
    vecs[16] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0040, 0, 1, 0);
    vecs[17] = mk(0, 1, 16'h0009, 0, 1,  1, 16'h0041, 1, 0, 0);
    vecs[18] = mk(0, 1, 16'h0100, 0, 1,  1, 16'h0009, 0, 1, 0); // redirect at accept
    vecs[19] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0100, 0, 1, 0);
    vecs[20] = mk(1, 1, 16'h001f, 0, 1,  0, 16'h0101, 1, 0, 0); // idle redirect
    vecs[21] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h001f, 0, 1, 0);
    vecs[22] = mk(0, 0, 16'h0000, 0, 0,  1, 16'h0020, 1, 0, 0);
    vecs[23] = mk(0, 0, 16'h0000, 1, 0,  1, 16'h0020, 0, 0, 0); // halt -> DRAIN
    vecs[24] = mk(1, 0, 16'h0000, 0, 0,  1, 16'h0020, 0, 0, 0);
    vecs[25] = mk(0, 0, 16'h0000, 0, 1,  1, 16'h0020, 0, 0, 0);
    vecs[26] = mk(0, 1, 16'h0055, 1, 1,  0, 16'h0021, 1, 0, 1); // HALT ignores inputs
    vecs[27] = mk(0, 0, 16'h0000, 0, 1,  0, 16'h0021, 0, 0, 1);

    rst = 1'b0;
    drive(0, 0, '0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].target, vecs[i].halt, vecs[i].ready);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_irv,
          vecs[i].e_flush, vecs[i].e_halted);
      @(negedge clk);
    end

    // Asynchronous reset from HALT, away from any clock edge.
    #2 rst = 1'b0;
    #1 chk("async_rst_halt", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, '0, 0, 1);
    #1 chk("wrap_boot", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 16'hffff, 0, 1);
    #1 chk("wrap_redirect", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, '0, 0, 1);
    #1 chk("wrap_at_max", 1, 16'hffff, 0, 1, 0);
    @(negedge clk);
    #1 chk("wrap_to_zero", 1, 16'h0000, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    #1 chk("wait_pc1", 1, 16'h0001, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 16'h0077, 0, 0);
    #1 chk("pend_capture", 1, 16'h0001, 0, 0, 0);

    // Reset mid-request must drop the request and the pending target.
    #2 rst = 1'b0;
    #1 chk("async_rst_req", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, '0, 0, 1);
    #1 chk("post_rst_boot", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    #1 chk("post_rst_run", 1, 16'h0000, 0, 0, 0);
    @(negedge clk);
    #1 chk("post_rst_noflush", 1, 16'h0001, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
